// File: rtl/hv_resp_parser.sv
// hv_resp_parser: delimits STX..ETX CS_H CS_L CR frames from the HV supply's
//   UART return stream, checks the ASCII-hex checksum and replays good payloads.
// Latency: byte at T updates state/pulses at T+1; first payload write at T+2 after good CR.
// Backpressure: dout_full stalls the drain combinationally (no loss, no duplicates);
//   bytes arriving while draining are dropped and flagged.
// Ports:
//   clk, rst_n (async, active low), soft_rst (sync clear, keeps frame_cnt)
//   din/din_valid        : received byte + one-cycle strobe
//   dout/dout_valid      : payload byte + write enable to readout FIFO; dout_full stalls
//   frame_done/frame_err : one-cycle pulses; err_code holds the last error
//   frame_len/frame_cnt  : length of last good frame / good-frame counter
//   busy                 : parser not idle
module hv_resp_parser #(
  parameter int MAX_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        soft_rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_full,
  output logic        frame_done,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [7:0]  frame_len,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]    STX      = 8'h02;
  localparam logic [7:0]    ETX      = 8'h03;
  localparam logic [7:0]    CR       = 8'h0D;
  localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] E_RESYNC   = 3'd1;
  localparam logic [2:0] E_FORMAT   = 3'd2;
  localparam logic [2:0] E_OVERFLOW = 3'd3;
  localparam logic [2:0] E_HEX      = 3'd4;
  localparam logic [2:0] E_CHECKSUM = 3'd5;
  localparam logic [2:0] E_TIMEOUT  = 3'd6;
  localparam logic [2:0] E_DROPPED  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_PAYLOAD, S_CS_H, S_CS_L, S_WAIT_CR, S_DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    len, len_nxt;
  logic [7:0]    sum, sum_nxt;
  logic [7:0]    rd_ptr, rd_nxt;
  logic [3:0]    cs_hi, cs_hi_nxt;
  logic [3:0]    cs_lo, cs_lo_nxt;
  logic          armed, armed_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    mem [0:MAX_LEN-1];

  logic          wr_en;
  logic          err_set;
  logic [2:0]    err_nxt;
  logic          done_set;
  logic          in_frame;
  logic          timed_out;
  logic [4:0]    hex;

  // {valid, nibble}; only uppercase hex digits are accepted.
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
    else                               return 5'd0;
  endfunction

  assign busy     = (state != S_IDLE);
  assign in_frame = (state == S_PAYLOAD) || (state == S_CS_H) ||
                    (state == S_CS_L)    || (state == S_WAIT_CR);

  // tmo_cnt holds the number of cycles since the last strobe, so the timeout
  // pulse lands exactly TIMEOUT_CYCLES cycles after the last byte.
  assign timed_out = in_frame && !din_valid && (tmo_cnt == TMO_LAST);
  assign hex       = hex_val(din);

  always_comb begin
    state_nxt  = state;
    len_nxt    = len;
    sum_nxt    = sum;
    rd_nxt     = rd_ptr;
    cs_hi_nxt  = cs_hi;
    cs_lo_nxt  = cs_lo;
    armed_nxt  = armed;
    wr_en      = 1'b0;
    err_set    = 1'b0;
    err_nxt    = 3'd0;
    done_set   = 1'b0;
    dout_valid = 1'b0;
    dout       = 8'h00;

    case (state)
      S_IDLE: begin
        if (din_valid && din == STX) begin
          state_nxt = S_PAYLOAD;
          len_nxt   = 8'd0;
          sum_nxt   = STX;
        end
      end

      S_PAYLOAD, S_CS_H, S_CS_L, S_WAIT_CR: begin
        if (timed_out) begin
          err_set   = 1'b1;
          err_nxt   = E_TIMEOUT;
          state_nxt = S_IDLE;
        end else if (din_valid) begin
          if (din == STX) begin
            // Abandon the partial frame and restart on this STX.
            err_set   = 1'b1;
            err_nxt   = E_RESYNC;
            state_nxt = S_PAYLOAD;
            len_nxt   = 8'd0;
            sum_nxt   = STX;
          end else begin
            case (state)
              S_PAYLOAD: begin
                if (din == ETX) begin
                  if (len == 8'd0) begin
                    err_set   = 1'b1;
                    err_nxt   = E_FORMAT;
                    state_nxt = S_IDLE;
                  end else begin
                    sum_nxt   = sum + ETX;
                    state_nxt = S_CS_H;
                  end
                end else if (din == CR) begin
                  err_set   = 1'b1;
                  err_nxt   = E_FORMAT;
                  state_nxt = S_IDLE;
                end else if (len == LEN_MAX) begin
                  err_set   = 1'b1;
                  err_nxt   = E_OVERFLOW;
                  state_nxt = S_IDLE;
                end else begin
                  wr_en   = 1'b1;
                  len_nxt = len + 8'd1;
                  sum_nxt = sum + din;
                end
              end
              S_CS_H: begin
                if (hex[4]) begin
                  cs_hi_nxt = hex[3:0];
                  state_nxt = S_CS_L;
                end else begin
                  err_set   = 1'b1;
                  err_nxt   = E_HEX;
                  state_nxt = S_IDLE;
                end
              end
              S_CS_L: begin
                if (hex[4]) begin
                  cs_lo_nxt = hex[3:0];
                  state_nxt = S_WAIT_CR;
                end else begin
                  err_set   = 1'b1;
                  err_nxt   = E_HEX;
                  state_nxt = S_IDLE;
                end
              end
              S_WAIT_CR: begin
                if (din == CR) begin
                  if ({cs_hi, cs_lo} == sum) begin
                    done_set  = 1'b1;
                    state_nxt = S_DRAIN;
                    rd_nxt    = 8'd0;
                    armed_nxt = 1'b0;
                  end else begin
                    err_set   = 1'b1;
                    err_nxt   = E_CHECKSUM;
                    state_nxt = S_IDLE;
                  end
                end else begin
                  err_set   = 1'b1;
                  err_nxt   = E_FORMAT;
                  state_nxt = S_IDLE;
                end
              end
              default: state_nxt = S_IDLE;
            endcase
          end
        end
      end

      S_DRAIN: begin
        // First DRAIN cycle is a settle cycle; writes start on the next one.
        armed_nxt  = 1'b1;
        dout_valid = armed && !dout_full && !soft_rst;
        if (dout_valid) begin
          dout = mem[rd_ptr[AW-1:0]];
          if (rd_ptr == len - 8'd1) state_nxt = S_IDLE;
          else                      rd_nxt    = rd_ptr + 8'd1;
        end
        if (din_valid) begin
          err_set = 1'b1;
          err_nxt = E_DROPPED;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state <= S_IDLE;
    else if (soft_rst) state <= S_IDLE;
    else               state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len        <= 8'd0;
      sum        <= 8'd0;
      rd_ptr     <= 8'd0;
      cs_hi      <= 4'd0;
      cs_lo      <= 4'd0;
      armed      <= 1'b0;
      tmo_cnt    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 3'd0;
      frame_len  <= 8'd0;
      frame_cnt  <= 16'd0;
    end else if (soft_rst) begin
      len        <= 8'd0;
      sum        <= 8'd0;
      rd_ptr     <= 8'd0;
      cs_hi      <= 4'd0;
      cs_lo      <= 4'd0;
      armed      <= 1'b0;
      tmo_cnt    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 3'd0;
      frame_len  <= 8'd0;
    end else begin
      len        <= len_nxt;
      sum        <= sum_nxt;
      rd_ptr     <= rd_nxt;
      cs_hi      <= cs_hi_nxt;
      cs_lo      <= cs_lo_nxt;
      armed      <= armed_nxt;
      frame_done <= done_set;
      frame_err  <= err_set;
      if (din_valid)     tmo_cnt <= TW'(1);
      else if (in_frame) tmo_cnt <= tmo_cnt + TW'(1);
      if (err_set) err_code <= err_nxt;
      if (done_set) begin
        frame_len <= len;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Payload buffer; no reset needed, length bookkeeping guards every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[len[AW-1:0]] <= din;
  end

endmodule

// File: tb/tb_hv_resp_parser.sv
module tb_hv_resp_parser;
  localparam int MAXL = 32;
  localparam int TMO  = 300;

  logic        clk = 1'b0;
  logic        rst_n, soft_rst, din_valid, dout_full;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_valid, frame_done, frame_err, busy;
  logic [2:0]  err_code;
  logic [7:0]  frame_len;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  // Monitor-owned observations
  logic [7:0] got_q[$];
  int done_cnt = 0, err_cnt = 0, viol_cnt = 0;

  // Bench-owned expectations
  logic [7:0]  exp_q[$];
  int          exp_done = 0, exp_err = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic        rnd_full = 1'b0;

  hv_resp_parser #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
    .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_full(dout_full),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
    .frame_len(frame_len), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dout_valid) begin
      got_q.push_back(dout);
      if (dout_full) viol_cnt++;
    end
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    din = b;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    din = 8'h00;
    repeat (gap) step();
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // Checksum: STX + payload + ETX, modulo 256.
  function automatic logic [7:0] csum(input logic [7:0] p[$]);
    logic [7:0] s;
    s = 8'h02 + 8'h03;
    foreach (p[i]) s = s + p[i];
    return s;
  endfunction

  // Sends everything up to and including CS_L; caller sends CR.
  task automatic send_head(input logic [7:0] p[$], input logic [7:0] cs, input int gap);
    send(8'h02, gap);
    foreach (p[i]) send(p[i], gap);
    send(8'h03, gap);
    send(hexc(cs[7:4]), gap);
    send(hexc(cs[3:0]), gap);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && busy; i++) begin
      if (rnd_full) dout_full = ($urandom_range(0, 2) == 0);
      step();
    end
    dout_full = 1'b0;
    check(tag, busy, 0);
  endtask

  // Send a complete frame and check its outcome against the checksum rule.
  task automatic run_frame(input string tag, input logic [7:0] p[$], input logic [7:0] cs, input int gap);
    bit good;
    good = (cs == csum(p));
    send_head(p, cs, gap);
    send(8'h0D, 0);
    if (good) begin
      exp_cnt++;
      exp_done++;
      foreach (p[i]) exp_q.push_back(p[i]);
      check({tag, "_done"}, frame_done, 1);
      check({tag, "_err"}, frame_err, 0);
      check({tag, "_len"}, frame_len, p.size());
      check({tag, "_cnt"}, frame_cnt, exp_cnt);
    end else begin
      exp_err++;
      check({tag, "_err"}, frame_err, 1);
      check({tag, "_code"}, err_code, 5);
      check({tag, "_done"}, frame_done, 0);
      check({tag, "_cnt"}, frame_cnt, exp_cnt);
      check({tag, "_busy"}, busy, 0);
    end
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    logic [7:0] p[$];
    logic [7:0] b;
    int n0;

    rst_n = 1'b0; soft_rst = 1'b0; din = 8'h00; din_valid = 1'b0; dout_full = 1'b0;
    repeat (2) step();
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_code", err_code, 0);
    check("rst_len", frame_len, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Good frame, 20 idle cycles between bytes, cycle-exact drain
    p.delete(); p.push_back(8'h56); p.push_back(8'h31);
    send_head(p, 8'h8C, 20);
    send(8'h0D, 0);
    exp_cnt++; exp_done++; exp_q.push_back(8'h56); exp_q.push_back(8'h31);
    check("g1_done", frame_done, 1);
    check("g1_len", frame_len, 2);
    check("g1_cnt", frame_cnt, 1);
    check("g1_code", err_code, 0);
    check("g1_no_early_write", dout_valid, 0);
    step();
    check("g1_v0", dout_valid, 1);
    check("g1_d0", dout, 8'h56);
    step();
    check("g1_v1", dout_valid, 1);
    check("g1_d1", dout, 8'h31);
    step();
    check("g1_v2", dout_valid, 0);
    check("g1_idle", busy, 0);

    // Bad checksum then good frame
    run_frame("badcs", p, 8'h8D, 20);
    run_frame("good2", p, 8'h8C, 2);

    // Overflow on 33rd payload byte
    send(8'h02, 1);
    for (int i = 0; i < MAXL; i++) begin
      b = 8'h41 + 8'(i % 26);
      send(b, 1);
    end
    check("ovf_pre_err", frame_err, 0);
    check("ovf_pre_busy", busy, 1);
    send(8'h5A, 0);
    exp_err++;
    check("ovf_err", frame_err, 1);
    check("ovf_code", err_code, 3);
    check("ovf_busy", busy, 0);
    step();

    // Lowercase checksum digit
    send(8'h02, 2); send(8'h56, 2); send(8'h31, 2); send(8'h03, 2); send(8'h38, 2);
    send(8'h63, 0);
    exp_err++;
    check("hex_err", frame_err, 1);
    check("hex_code", err_code, 4);
    check("hex_busy", busy, 0);
    step();

    // Soft reset clears status but keeps the frame counter
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    check("srst_code", err_code, 0);
    check("srst_cnt", frame_cnt, exp_cnt);
    check("srst_len", frame_len, 0);

    // Timeout: error exactly TMO cycles after the last strobe
    send(8'h02, 20);
    send(8'h56, 0);
    repeat (TMO - 2) step();
    check("tmo_early", frame_err, 0);
    check("tmo_early_busy", busy, 1);
    step();
    exp_err++;
    check("tmo_err", frame_err, 1);
    check("tmo_code", err_code, 6);
    check("tmo_busy", busy, 0);
    step();
    check("tmo_pulse", frame_err, 0);

    // Resync: second STX restarts the frame
    send(8'h02, 3); send(8'h56, 3);
    send(8'h02, 0);
    exp_err++;
    check("rs_err", frame_err, 1);
    check("rs_code", err_code, 1);
    check("rs_busy", busy, 1);
    repeat (3) step();
    send(8'h56, 3); send(8'h31, 3); send(8'h03, 3); send(8'h38, 3); send(8'h43, 3);
    send(8'h0D, 0);
    exp_cnt++; exp_done++; exp_q.push_back(8'h56); exp_q.push_back(8'h31);
    check("rs_done", frame_done, 1);
    check("rs_cnt", frame_cnt, exp_cnt);
    wait_idle("rs_idle");

    // Backpressure for 10 cycles, plus a byte dropped during DRAIN
    p.delete(); p.push_back(8'h41); p.push_back(8'h42); p.push_back(8'h43);
    send_head(p, csum(p), 2);
    dout_full = 1'b1;
    send(8'h0D, 0);
    exp_cnt++; exp_done++;
    foreach (p[i]) exp_q.push_back(p[i]);
    check("bp_done", frame_done, 1);
    check("bp_len", frame_len, 3);
    n0 = got_q.size();
    step(); step();
    send(8'h55, 0);
    exp_err++;
    check("drop_err", frame_err, 1);
    check("drop_code", err_code, 7);
    check("drop_busy", busy, 1);
    repeat (6) step();
    check("bp_nowrite_v", dout_valid, 0);
    check("bp_nowrite_n", got_q.size(), n0);
    dout_full = 1'b0;
    #1;
    check("bp_v0", dout_valid, 1);
    check("bp_d0", dout, 8'h41);
    step();
    check("bp_v1", dout_valid, 1);
    check("bp_d1", dout, 8'h42);
    step();
    check("bp_v2", dout_valid, 1);
    check("bp_d2", dout, 8'h43);
    step();
    check("bp_end", dout_valid, 0);
    check("bp_idle", busy, 0);

    // Randomized frames with random backpressure
    rnd_full = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      logic [7:0] cs;
      p.delete();
      len = $urandom_range(1, MAXL);
      for (int i = 0; i < len; i++) begin
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h02 || b == 8'h03 || b == 8'h0D);
        p.push_back(b);
      end
      cs = csum(p);
      if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
      run_frame($sformatf("rnd%0d", f), p, cs, $urandom_range(0, 3));
    end
    rnd_full = 1'b0;

    // Async reset in the middle of a drain
    p.delete(); p.push_back(8'h58); p.push_back(8'h59); p.push_back(8'h5A);
    send_head(p, csum(p), 1);
    send(8'h0D, 0);
    exp_done++;
    step();
    check("mr_v0", dout_valid, 1);
    check("mr_d0", dout, 8'h58);
    exp_q.push_back(8'h58);
    step();
    rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    check("mr_dout_valid", dout_valid, 0);
    check("mr_dout", dout, 0);
    check("mr_busy", busy, 0);
    check("mr_cnt", frame_cnt, 0);
    check("mr_len", frame_len, 0);
    check("mr_code", err_code, 0);
    step();
    rst_n = 1'b1;
    step();
    p.delete(); p.push_back(8'h56); p.push_back(8'h31);
    run_frame("after_rst", p, 8'h8C, 2);

    // Whole output stream and event totals
    repeat (3) step();
    check("stream_size", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("stream[%0d]", i), got_q[i], exp_q[i]);
    check("write_while_full", viol_cnt, 0);
    check("done_total", done_cnt, exp_done);
    check("err_total", err_cnt, exp_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
